// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: data width, default baud divisor and FSM states.
// ST_PARITY only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_CLK_DIV = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset high so that an idle line is seen during and after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled mid-bit with a down-counting baud counter.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int            CW          = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_IDX    = 3'(DATA_BITS - 1);

    logic                 w_rxs;
    logic                 w_expired;
    logic                 w_byteDone;
    logic                 w_frameBad;
    rx_state_t            r_state;
    rx_state_t            w_nextState;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_nextCnt;
    logic [2:0]           r_idx;
    logic [2:0]           w_nextIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_nextShift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_frameErr;
    logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 r_parBad;
    logic                 w_nextParBad;
    logic                 w_parityBad;
    logic                 r_parityErr;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (ser_rx),
        .o_sync  (w_rxs)
    );

    assign w_expired = (r_cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
`ifdef UART_RX_PARITY_EN
            r_parBad <= 1'b0;
`endif
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_idx    <= w_nextIdx;
            r_shift  <= w_nextShift;
`ifdef UART_RX_PARITY_EN
            r_parBad <= w_nextParBad;
`endif
        end
    end

    // The STOP decision returns to IDLE immediately so a back-to-back start edge is never missed.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_nextShift = r_shift;
        w_byteDone  = 1'b0;
        w_frameBad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_nextParBad = r_parBad;
        w_parityBad  = 1'b0;
`endif
        if (r_state != ST_IDLE && !w_expired) begin
            w_nextCnt = r_cnt - CW'(1);
        end
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_nextState = ST_START;
                    w_nextCnt   = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (w_expired) begin
                    if (w_rxs) begin
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextState = ST_DATA;
                        w_nextIdx   = '0;
                        w_nextCnt   = FULL_RELOAD;
                    end
                end
            end
            ST_DATA: begin
                if (w_expired) begin
                    w_nextShift[r_idx] = w_rxs;
                    w_nextCnt          = FULL_RELOAD;
                    w_nextIdx          = r_idx + 3'd1;
                    if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        w_nextState = ST_PARITY;
`else
                        w_nextState = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_expired) begin
                    w_nextParBad = (w_rxs != ^r_shift);
                    w_nextCnt    = FULL_RELOAD;
                    w_nextState  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_expired) begin
                    w_nextState = ST_IDLE;
                    w_frameBad  = !w_rxs;
`ifdef UART_RX_PARITY_EN
                    w_parityBad = r_parBad;
                    w_byteDone  = w_rxs && !r_parBad;
`else
                    w_byteDone  = w_rxs;
`endif
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Holding register: a completing byte wins over a same-cycle acceptance, and is dropped only if nobody is taking the old one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frameErr <= w_frameBad;
            r_overrun  <= 1'b0;
            if (w_byteDone) begin
                if (r_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_parityErr <= 1'b0;
        end else begin
            r_parityErr <= w_parityBad;
        end
    end

    assign parity_err = r_parityErr;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_DIV=16: directed scenarios plus random frames
// checked against a queue-based frame model. Honours UART_RX_PARITY_EN like the DUT.
module tb_uart_rx;

    localparam int CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAYLOAD_BITS = 9;
`else
    localparam int PAYLOAD_BITS = 8;
`endif
    // 2 sync flops + 1 detect edge, half a bit to mid-start, then every remaining bit up to mid-stop.
    localparam int LATENCY = 3 + CLK_DIV / 2 + PAYLOAD_BITS * CLK_DIV + CLK_DIV;

    logic       clk;
    logic       resetn;
    logic       ser_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int testsRun = 0;
    int failCount = 0;
    int cycleCount = 0;
    int lastStartCycle = 0;
    int validRiseCycle = -1;
    int validHigh = 0;
    int frameErrCnt = 0;
    int overrunCnt = 0;
    int parityErrCnt = 0;
    int parityEverCnt = 0;
    logic prevValid = 1'b0;
    logic [7:0] gotQ[$];
    logic [7:0] expQ[$];
    int expFerr;

    uart_rx #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ser_rx     (ser_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Observer: records accepted bytes and the number of cycles each pulse output is high.
    always @(negedge clk) begin
        if (resetn) begin
            if (rx_valid && rx_ready) gotQ.push_back(rx_data);
            if (rx_valid) validHigh++;
            if (rx_valid && !prevValid) validRiseCycle = cycleCount;
            if (frame_err) frameErrCnt++;
            if (overrun) overrunCnt++;
            if (parity_err) begin
                parityErrCnt++;
                parityEverCnt++;
            end
        end
        prevValid = rx_valid;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] payloadOf(input logic [7:0] d, input logic goodPar);
        return {goodPar ? ^d : ~^d, d};
    endfunction

    // Sends one frame starting at the current negedge; ends on a negedge with the line idle.
    task automatic applyStimulus(input logic [8:0] payload, input logic stopBit);
        ser_rx = 1'b0;
        lastStartCycle = cycleCount;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < PAYLOAD_BITS; i++) begin
            ser_rx = payload[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        ser_rx = stopBit;
        repeat (CLK_DIV) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearCounters();
        @(posedge clk);
        #1;
        gotQ.delete();
        validHigh = 0;
        validRiseCycle = -1;
        frameErrCnt = 0;
        overrunCnt = 0;
        parityErrCnt = 0;
        @(negedge clk);
    endtask

    task automatic setReady(input logic v);
        @(posedge clk);
        #1;
        rx_ready = v;
        @(negedge clk);
    endtask

    function automatic logic [31:0] gotAt(input int i);
        return (i < gotQ.size()) ? {24'd0, gotQ[i]} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [7:0] b;
        logic       stopOk;

        resetn   = 1'b1;
        ser_rx   = 1'b1;
        rx_ready = 1'b0;
        #1 resetn = 1'b0;
        idle(4);
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset rx_data", rx_data, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset parity_err", parity_err, 0);
        resetn = 1'b1;
        idle(4);

        // Single clean byte with consumer always ready
        setReady(1'b1);
        clearCounters();
        applyStimulus(payloadOf(8'hA5, 1'b1), 1'b1);
        idle(3 * CLK_DIV);
        checkOutput("A5 count", gotQ.size(), 1);
        checkOutput("A5 data", gotAt(0), 32'hA5);
        checkOutput("A5 valid width", validHigh, 1);
        checkOutput("A5 latency", validRiseCycle - lastStartCycle, LATENCY);
        checkOutput("A5 frame_err", frameErrCnt, 0);
        checkOutput("A5 overrun", overrunCnt, 0);
        checkOutput("A5 parity_err", parityErrCnt, 0);

        // Short low glitch must be rejected, and the next frame received normally
        clearCounters();
        ser_rx = 1'b0;
        idle(4);
        ser_rx = 1'b1;
        idle(2 * CLK_DIV);
        checkOutput("glitch valid", validHigh, 0);
        checkOutput("glitch errors", frameErrCnt + overrunCnt + parityErrCnt, 0);
        b = 8'($urandom_range(0, 255));
        applyStimulus(payloadOf(b, 1'b1), 1'b1);
        idle(2 * CLK_DIV);
        checkOutput("post-glitch count", gotQ.size(), 1);
        checkOutput("post-glitch data", gotAt(0), {24'd0, b});

        // Stop bit low
        clearCounters();
        applyStimulus(payloadOf(8'h3C, 1'b1), 1'b0);
        idle(3 * CLK_DIV);
        checkOutput("ferr pulse cycles", frameErrCnt, 1);
        checkOutput("ferr valid", validHigh, 0);
        checkOutput("ferr overrun", overrunCnt, 0);

        // Random frames, some with a bad stop bit, against the frame model
        clearCounters();
        expQ.delete();
        expFerr = 0;
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom_range(0, 255));
            stopOk = ($urandom_range(0, 3) != 0);
            if (stopOk) expQ.push_back(b);
            else expFerr++;
            applyStimulus(payloadOf(b, 1'b1), stopOk);
            idle(2 * CLK_DIV);
        end
        checkOutput("rand count", gotQ.size(), expQ.size());
        checkOutput("rand ferr", frameErrCnt, expFerr);
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("rand byte %0d", i), gotAt(i), {24'd0, expQ[i]});
        end

        // Back-to-back random frames, no idle gap
        clearCounters();
        expQ.delete();
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom_range(0, 255));
            expQ.push_back(b);
            applyStimulus(payloadOf(b, 1'b1), 1'b1);
        end
        idle(2 * CLK_DIV);
        checkOutput("b2b count", gotQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("b2b byte %0d", i), gotAt(i), {24'd0, expQ[i]});
        end

        // Overrun: consumer stalled across two frames
        setReady(1'b0);
        clearCounters();
        applyStimulus(payloadOf(8'h11, 1'b1), 1'b1);
        applyStimulus(payloadOf(8'h22, 1'b1), 1'b1);
        idle(2 * CLK_DIV);
        checkOutput("ovr valid held", rx_valid, 1);
        checkOutput("ovr data held", rx_data, 32'h11);
        checkOutput("ovr pulse cycles", overrunCnt, 1);
        checkOutput("ovr ferr", frameErrCnt, 0);
        setReady(1'b1);
        idle(2);
        checkOutput("ovr accepted count", gotQ.size(), 1);
        checkOutput("ovr accepted data", gotAt(0), 32'h11);
        checkOutput("ovr valid cleared", rx_valid, 0);

        // Reset in the middle of data bit 3, then a clean frame
        clearCounters();
        b = 8'hC3;
        ser_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ser_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        ser_rx = b[3];
        repeat (CLK_DIV / 2) @(negedge clk);
        resetn = 1'b0;
        #2;
        checkOutput("midreset rx_valid", rx_valid, 0);
        checkOutput("midreset rx_data", rx_data, 0);
        checkOutput("midreset frame_err", frame_err, 0);
        checkOutput("midreset overrun", overrun, 0);
        checkOutput("midreset parity_err", parity_err, 0);
        ser_rx = 1'b1;
        idle(4);
        resetn = 1'b1;
        idle(2 * CLK_DIV);
        clearCounters();
        applyStimulus(payloadOf(8'h5A, 1'b1), 1'b1);
        idle(3 * CLK_DIV);
        checkOutput("postreset count", gotQ.size(), 1);
        checkOutput("postreset data", gotAt(0), 32'h5A);
        checkOutput("postreset errors", frameErrCnt + overrunCnt + parityErrCnt, 0);

`ifdef UART_RX_PARITY_EN
        clearCounters();
        applyStimulus(9'h007, 1'b1);
        idle(3 * CLK_DIV);
        checkOutput("par bad pulse cycles", parityErrCnt, 1);
        checkOutput("par bad valid", validHigh, 0);
        checkOutput("par bad ferr", frameErrCnt, 0);
        clearCounters();
        applyStimulus(9'h107, 1'b1);
        idle(3 * CLK_DIV);
        checkOutput("par good count", gotQ.size(), 1);
        checkOutput("par good data", gotAt(0), 32'h07);
        checkOutput("par good perr", parityErrCnt, 0);
`else
        checkOutput("parity_err never high", parityEverCnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
